// File: rtl/r_type_encoder_pkg.sv
// Shared RV32I OP-class encoding constants, the R-type operation enum and the
// kind -> {illegal, funct7, funct3} lookup used by both encoder and decoder checks.
package r_type_encoder_pkg;

  typedef enum logic [3:0] {
    RAK_ADD  = 4'd0,
    RAK_SUB  = 4'd1,
    RAK_SLL  = 4'd2,
    RAK_SLT  = 4'd3,
    RAK_SLTU = 4'd4,
    RAK_XOR  = 4'd5,
    RAK_SRL  = 4'd6,
    RAK_SRA  = 4'd7,
    RAK_OR   = 4'd8,
    RAK_AND  = 4'd9
  } reg_arith_kind_t;

  typedef struct packed {
    logic       illegal;
    logic [6:0] funct7;
    logic [2:0] funct3;
  } rak_funct_t;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // FIFO entry is {illegal, instr}
  localparam int FIFO_WIDTH = 33;

  function automatic rak_funct_t rak_to_funct(input reg_arith_kind_t kind);
    rak_funct_t r;
    r.illegal = 1'b0;
    r.funct7  = FUNCT7_BASE;
    r.funct3  = 3'b000;
    case (kind)
      RAK_ADD:  r.funct3 = 3'b000;
      RAK_SUB:  begin r.funct3 = 3'b000; r.funct7 = FUNCT7_ALT; end
      RAK_SLL:  r.funct3 = 3'b001;
      RAK_SLT:  r.funct3 = 3'b010;
      RAK_SLTU: r.funct3 = 3'b011;
      RAK_XOR:  r.funct3 = 3'b100;
      RAK_SRL:  r.funct3 = 3'b101;
      RAK_SRA:  begin r.funct3 = 3'b101; r.funct7 = FUNCT7_ALT; end
      RAK_OR:   r.funct3 = 3'b110;
      RAK_AND:  r.funct3 = 3'b111;
      default:  r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/r_type_encoder_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; owns pointers and occupancy.
// Read data is forced to zero while empty so consumers never see stale entries.
module r_type_encoder_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  // Requests against a full/empty FIFO are ignored here, not upstream.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/r_type_encoder.sv
// Assembles RV32I OP-class words from an operation kind plus register indices and
// queues them, with an illegal flag, behind valid/ready handshakes on both sides.
module r_type_encoder
  import r_type_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  reg_arith_kind_t        in_kind,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            retired_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload until then, and ready never depends on valid.
  rak_funct_t            w_funct;
  logic [31:0]           w_word;
  logic [FIFO_WIDTH-1:0] w_rdata;
  logic                  w_full;
  logic                  w_empty;
  logic [31:0]           r_retired;

  assign w_funct = rak_to_funct(in_kind);
  assign w_word  = w_funct.illegal ? 32'h0000_0000
                 : {w_funct.funct7, in_rs2, in_rs1, w_funct.funct3, in_rd, OPCODE_OP};

  r_type_encoder_sync_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_wdata ({w_funct.illegal, w_word}),
    .i_pop   (out_ready),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  assign in_ready    = !w_full;
  assign out_valid   = !w_empty;
  assign out_illegal = w_rdata[32];
  assign out_instr   = w_rdata[31:0];
  assign retired_cnt = r_retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (out_valid && out_ready) begin
      r_retired <= r_retired + 32'd1;
    end
  end

endmodule
